// File: rtl/uart_tx_arbiter_if.sv
// Requester handshakes plus the transmitter-side outputs of the UART arbiter.
// The master modport is the requester/transmitter side; slave is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
) ();
  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               start_tx;
  logic [7:0]         data_tx;
  logic [GW-1:0]      grant_id;
  logic               busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, start_tx, data_tx, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, start_tx, data_tx, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte sources and times each frame.
// Define UART_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = 57299,
  parameter int GAP_CYCLES   = 0
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int GW      = $clog2(N_REQ);
  localparam int CNT_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] FRAME_LD = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]    r_data;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] w_win;
  logic          w_any;
  logic          w_accept;

`ifdef UART_ARB_RR_EN
  logic [GW-1:0] r_ptr;

  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] ptr, input int k);
    return GW'((int'(ptr) + k) % N_REQ);
  endfunction

  // Scan from farthest to nearest so the slot right after the pointer wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (bus.req_valid[rr_idx(r_ptr, k)]) begin
        w_any = 1'b1;
        w_win = rr_idx(r_ptr, k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           r_ptr <= GW'(N_REQ - 1);
    else if (w_accept) r_ptr <= w_win;
  end
`else
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        w_any = 1'b1;
        w_win = GW'(i);
      end
    end
  end
`endif

  assign w_accept = (r_state == S_IDLE) && w_any;

  always_comb begin
    bus.req_ready = '0;
    if (w_accept) bus.req_ready[w_win] = 1'b1;
  end

  always_comb begin
    // NOTE: defaults come first so no branch leaves a signal unassigned (no latch).
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: if (w_any) begin
        w_state_nxt = S_START;
        w_cnt_nxt   = FRAME_LD;
      end
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_cnt == '0) begin
          if (GAP_CYCLES == 0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = GAP_LD;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A reset drops any accepted byte; the requester is not asked again.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values.
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_data  <= 8'h00;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_data  <= bus.req_data[{w_win, 3'b000} +: 8];
        r_grant <= w_win;
      end
    end
  end

  assign bus.start_tx = (r_state == S_START);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.data_tx  = r_data;
  assign bus.grant_id = r_grant;
endmodule
